// File: rtl/voting_pkg.sv
// Shared types and sizing for the 16-voter / 4-candidate voting datapath.
// The ballot typedef is also imported by the downstream winner stage.
package voting_pkg;

  localparam int N_VOTERS = 16;
  localparam int CAND_W   = 2;
  localparam int ID_W     = $clog2(N_VOTERS);
  localparam int COUNT_W  = ID_W + 1;
  localparam int BALLOT_W = N_VOTERS * CAND_W;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_e;

  typedef logic [BALLOT_W-1:0] ballot_t;
  typedef logic [N_VOTERS-1:0] mask_t;
  typedef logic [COUNT_W-1:0]  count_t;
  typedef logic [ID_W-1:0]     id_t;
  typedef logic [CAND_W-1:0]   cand_t;

  // Field of voter i inside a packed ballot; voter i sits at [2i+1:2i].
  function automatic cand_t ballot_field(input ballot_t b, input id_t i);
    return b[int'(i)*CAND_W +: CAND_W];
  endfunction

endpackage

// File: rtl/voting_ballot_collector_if.sv
// Vote stream in, held ballot out: all handshake and data signals of the collector.
// The collector uses the slave modport; the upstream/downstream side uses master.
interface voting_ballot_collector_if;
  import voting_pkg::*;

  logic    vote_valid;
  logic    vote_ready;
  id_t     vote_id;
  cand_t   vote_cand;
  logic    close;
  logic    ballot_valid;
  logic    ballot_ready;
  ballot_t ballot;
  mask_t   voted_mask;
  count_t  vote_count;
  logic    dup_err;

  modport master (
    output vote_valid, vote_id, vote_cand, close, ballot_ready,
    input  vote_ready, ballot_valid, ballot, voted_mask, vote_count, dup_err
  );

  modport slave (
    input  vote_valid, vote_id, vote_cand, close, ballot_ready,
    output vote_ready, ballot_valid, ballot, voted_mask, vote_count, dup_err
  );

endinterface

// File: rtl/voting_ballot_collector.sv
// Collects one vote per cycle, rejects repeat voters, and presents the packed
// ballot (held stable) once everyone has voted or an early close arrives.
module voting_ballot_collector
  import voting_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  voting_ballot_collector_if.slave bus
);

  state_e  state_q, state_d;
  ballot_t ballot_q, ballot_d;
  mask_t   voted_mask_q, voted_mask_d;
  count_t  vote_count_q, vote_count_d;
  logic    ballot_valid_q, ballot_valid_d;
  logic    dup_err_q, dup_err_d;

  logic    offer;
  logic    is_dup;
  logic    accept;
  mask_t   id_onehot;

  // vote_ready depends on state only, so upstream never sees a combinational loop.
  assign offer  = bus.vote_valid && (state_q == COLLECT);
  assign is_dup = offer && voted_mask_q[bus.vote_id];
  assign accept = offer && !is_dup;

  always_comb begin
    id_onehot              = '0;
    id_onehot[bus.vote_id] = 1'b1;
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    state_d      = state_q;
    ballot_d     = ballot_q;
    voted_mask_d = voted_mask_q;
    vote_count_d = vote_count_q;
    dup_err_d    = 1'b0;

    case (state_q)
      COLLECT: begin
        dup_err_d = is_dup;
        if (accept) begin
          for (int i = 0; i < N_VOTERS; i++) begin
            if (id_onehot[i]) ballot_d[i*CAND_W +: CAND_W] = bus.vote_cand;
          end
          voted_mask_d = voted_mask_q | id_onehot;
          vote_count_d = vote_count_q + count_t'(1);
        end
        // A vote coinciding with close is still recorded before the ballot freezes.
        if ((accept && vote_count_q == count_t'(N_VOTERS - 1)) || bus.close) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.ballot_ready) begin
          state_d      = COLLECT;
          ballot_d     = '0;
          voted_mask_d = '0;
          vote_count_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase

    ballot_valid_d = (state_d == PRESENT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= COLLECT;
      ballot_q       <= '0;
      voted_mask_q   <= '0;
      vote_count_q   <= '0;
      ballot_valid_q <= 1'b0;
      dup_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ballot_q       <= ballot_d;
      voted_mask_q   <= voted_mask_d;
      vote_count_q   <= vote_count_d;
      ballot_valid_q <= ballot_valid_d;
      dup_err_q      <= dup_err_d;
    end
  end

  assign bus.vote_ready   = (state_q == COLLECT);
  assign bus.ballot_valid = ballot_valid_q;
  assign bus.ballot       = ballot_q;
  assign bus.voted_mask   = voted_mask_q;
  assign bus.vote_count   = vote_count_q;
  assign bus.dup_err      = dup_err_q;

endmodule

// File: tb/tb_voting_ballot_collector.sv
// Self-checking bench: directed scenarios plus random traffic against a
// per-voter reference model, with a scoreboard of expected presented ballots.
module tb_voting_ballot_collector;
  import voting_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voting_ballot_collector_if bus();

  voting_ballot_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each voter's recorded choice, -1 meaning not yet voted.
  int  votes[N_VOTERS];
  bit  m_open;
  int  cyc;
  bit  mon_en = 1'b0;

  // Expectations for what the outputs show in the current cycle.
  bit      e_open;
  ballot_t e_ballot;
  mask_t   e_mask;
  int      e_count;

  typedef struct {
    ballot_t b;
    mask_t   m;
    int      c;
  } result_t;

  result_t sb_q[$];
  int      dup_q[$];

  function automatic ballot_t model_ballot();
    ballot_t b = '0;
    for (int i = 0; i < N_VOTERS; i++)
      if (votes[i] >= 0) b[i*CAND_W +: CAND_W] = cand_t'(votes[i]);
    return b;
  endfunction

  function automatic mask_t model_mask();
    mask_t m = '0;
    for (int i = 0; i < N_VOTERS; i++) m[i] = (votes[i] >= 0);
    return m;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < N_VOTERS; i++) if (votes[i] >= 0) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_VOTERS; i++) votes[i] = -1;
  endtask

  task automatic refresh_expect();
    e_open   = m_open;
    e_ballot = model_ballot();
    e_mask   = model_mask();
    e_count  = model_count();
  endtask

  // Apply one cycle of inputs, update the model for the coming edge, advance.
  task automatic drive(input bit v, input int id, input int cand, input bit cl, input bit br);
    bus.vote_valid   = v;
    bus.vote_id      = id_t'(id);
    bus.vote_cand    = cand_t'(cand);
    bus.close        = cl;
    bus.ballot_ready = br;
    if (m_open) begin
      if (v) begin
        if (votes[id] >= 0) dup_q.push_back(cyc + 1);
        else votes[id] = cand;
      end
      if (model_count() == N_VOTERS || cl) begin
        sb_q.push_back('{model_ballot(), model_mask(), model_count()});
        m_open = 1'b0;
      end
    end else if (br) begin
      m_open = 1'b1;
      model_clear();
    end
    @(posedge clk);
    #1;
    cyc++;
    refresh_expect();
  endtask

  task automatic idle(input bit br);
    drive(1'b0, 0, 0, 1'b0, br);
  endtask

  // Monitor: compares live outputs and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      bit exp_dup;
      while (dup_q.size() > 0 && dup_q[0] < cyc) void'(dup_q.pop_front());
      exp_dup = (dup_q.size() > 0 && dup_q[0] == cyc);
      if (exp_dup) void'(dup_q.pop_front());
      check("dup_err", bus.dup_err, exp_dup);
      check("vote_ready", bus.vote_ready, e_open);
      check("ballot_valid", bus.ballot_valid, !e_open);
      check("ballot_live", bus.ballot, e_ballot);
      check("mask_live", bus.voted_mask, e_mask);
      check("count_live", bus.vote_count, e_count);
      if (bus.ballot_valid) begin
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          check("sb_ballot", bus.ballot, sb_q[0].b);
          check("sb_mask", bus.voted_mask, sb_q[0].m);
          check("sb_count", bus.vote_count, sb_q[0].c);
          if (bus.ballot_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ballot"}, bus.ballot, 0);
    check({tag, "_mask"}, bus.voted_mask, 0);
    check({tag, "_count"}, bus.vote_count, 0);
    check({tag, "_valid"}, bus.ballot_valid, 0);
    check({tag, "_dup"}, bus.dup_err, 0);
  endtask

  initial begin
    model_clear();
    m_open           = 1'b1;
    cyc              = 0;
    rst              = 1'b1;
    bus.vote_valid   = 1'b0;
    bus.vote_id      = '0;
    bus.vote_cand    = '0;
    bus.close        = 1'b0;
    bus.ballot_ready = 1'b0;
    #2;
    check_all_zero("reset");
    check("reset_ready", bus.vote_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    refresh_expect();
    mon_en = 1'b1;

    // Full round with ballot_ready held high: 1-cycle PRESENT.
    for (int i = 0; i < N_VOTERS; i++) drive(1'b1, i, i % 4, 1'b0, 1'b1);
    check("full_ballot", bus.ballot, 64'hE4E4E4E4);
    check("full_valid", bus.ballot_valid, 1);
    check("full_count", bus.vote_count, 16);
    check("full_mask", bus.voted_mask, 64'hFFFF);
    idle(1'b1);
    check("full_clear_valid", bus.ballot_valid, 0);
    check("full_clear_ballot", bus.ballot, 0);
    check("full_clear_count", bus.vote_count, 0);
    check("full_clear_ready", bus.vote_ready, 1);

    // Duplicate vote: first vote wins.
    drive(1'b1, 3, 2, 1'b0, 1'b0);
    drive(1'b1, 3, 1, 1'b0, 1'b0);
    check("dup_pulse", bus.dup_err, 1);
    check("dup_field", ballot_field(bus.ballot, id_t'(3)), 2);
    check("dup_count", bus.vote_count, 1);
    idle(1'b0);
    check("dup_pulse_end", bus.dup_err, 0);
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    idle(1'b1);

    // Early close coinciding with the second vote.
    drive(1'b1, 0, 3, 1'b0, 1'b0);
    drive(1'b1, 1, 3, 1'b1, 1'b0);
    check("close_ballot", bus.ballot, 64'h0000000F);
    check("close_mask", bus.voted_mask, 64'h0003);
    check("close_count", bus.vote_count, 2);
    check("close_valid", bus.ballot_valid, 1);
    idle(1'b1);

    // Backpressure: ballot held while a vote burst and close are ignored.
    for (int i = 0; i < N_VOTERS; i++) drive(1'b1, i, i % 4, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'b0);
      check("bp_ballot", bus.ballot, 64'hE4E4E4E4);
      check("bp_valid", bus.ballot_valid, 1);
      check("bp_ready", bus.vote_ready, 0);
    end
    idle(1'b1);
    check("bp_release", bus.ballot_valid, 0);
    drive(1'b1, 5, 1, 1'b0, 1'b0);
    check("bp_restart_count", bus.vote_count, 1);
    check("bp_restart_mask", bus.voted_mask, 64'h0020);
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    idle(1'b1);

    // Close with no votes.
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    check("empty_valid", bus.ballot_valid, 1);
    check("empty_ballot", bus.ballot, 0);
    check("empty_count", bus.vote_count, 0);
    idle(1'b1);

    // Asynchronous reset between edges after 7 votes.
    for (int i = 0; i < 7; i++) drive(1'b1, i + 4, i % 4, 1'b0, 1'b0);
    check("pre_rst_count", bus.vote_count, 7);
    bus.vote_valid = 1'b0;
    bus.close      = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_clear();
    m_open = 1'b1;
    dup_q.delete();
    sb_q.delete();
    refresh_expect();
    #1 rst = 1'b0;
    check("post_rst_ready", bus.vote_ready, 1);
    @(posedge clk);
    #1;
    cyc++;
    refresh_expect();

    // Random traffic; duplicates, closes and backpressure arise naturally.
    for (int k = 0; k < 1500; k++) begin
      drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 2) != 0));
    end

    // Drain any outstanding ballot.
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("sb_drained", sb_q.size(), 0);
    check("dup_drained", dup_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
